// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block/state types, S-box, xtime, Rcon and
// the column-major byte-position helper used by the encrypt engine.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8), reducing with x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Bit position of the LSB of byte idx; byte 0 sits in bits [127:120],
  // bytes run down each column (idx = 4*col + row).
  function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
    return 7'd120 - {idx, 3'b000};
  endfunction

  // Round constant for rounds 1..10; anything else yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    if ((rnd >= 4'd1) && (rnd <= 4'd10)) begin
      r = RCON[rnd];
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_enc.sv
// One combinational AES encryption round:
// SubBytes -> ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey.
module aes_round_enc
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [7:0] sb_s [16];
  logic [7:0] sr_s [16];
  logic [7:0] mc_s [16];
  logic [7:0] mx_s [16];

  // Byte substitution, row rotation, column mixing and key addition.
  always_comb begin
    state_out = 128'h0;
    for (int i = 0; i < 16; i++) begin
      sb_s[i] = sbox(state_in[byte_lsb(4'(i)) +: 8]);
    end
    // Row r of column c takes the byte from column (c + r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[4*c + r] = sb_s[4*((c + r) % 4) + r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[4*c + 0] = xtime(sr_s[4*c+0]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1]
                    ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c + 1] = sr_s[4*c+0] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2])
                    ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c + 2] = sr_s[4*c+0] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2])
                    ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
      mc_s[4*c + 3] = xtime(sr_s[4*c+0]) ^ sr_s[4*c+0] ^ sr_s[4*c+1]
                    ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      if (final_round) begin
        mx_s[i] = sr_s[i];
      end else begin
        mx_s[i] = mc_s[i];
      end
      state_out[byte_lsb(4'(i)) +: 8] = mx_s[i] ^ round_key[byte_lsb(4'(i)) +: 8];
    end
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on
// the fly, valid/ready on both input and output.
// Optional macro AES_ENC_BACK2BACK_EN lets a new block be accepted on the
// same edge as the output handshake (DONE -> RUN directly).
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  state_e       fsm_r;
  block_t       data_r;
  block_t       key_r;
  logic [3:0]   rnd_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;
  block_t       ciphertext_r;

  block_t       rk_next_s;
  block_t       round_out_s;
  logic         last_round_s;
  logic [31:0]  rot_s;
  logic [31:0]  temp_s;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s;

  assign last_round_s = (rnd_r == 4'd10);

  // Next round key: RotWord, SubWord and Rcon on the last word, then the XOR chain.
  always_comb begin
    rot_s  = {key_r[23:0], key_r[31:24]};
    temp_s = {sbox(rot_s[31:24]) ^ rcon(rnd_r), sbox(rot_s[23:16]),
              sbox(rot_s[15:8]), sbox(rot_s[7:0])};
    w0_s   = key_r[127:96] ^ temp_s;
    w1_s   = key_r[95:64]  ^ w0_s;
    w2_s   = key_r[63:32]  ^ w1_s;
    w3_s   = key_r[31:0]   ^ w2_s;
    rk_next_s = {w0_s, w1_s, w2_s, w3_s};
  end

  aes_round_enc u_round (
    .state_in    (data_r),
    .round_key   (rk_next_s),
    .final_round (last_round_s),
    .state_out   (round_out_s)
  );

  // Control FSM with datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r        <= IDLE;
      data_r       <= 128'h0;
      key_r        <= 128'h0;
      rnd_r        <= 4'd0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      ciphertext_r <= 128'h0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (in_valid) begin
            data_r     <= plaintext ^ key;
            key_r      <= key;
            rnd_r      <= 4'd1;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            fsm_r      <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          data_r <= round_out_s;
          key_r  <= rk_next_s;
          if (last_round_s) begin
            ciphertext_r <= round_out_s;
            out_valid_r  <= 1'b1;
            busy_r       <= 1'b0;
            rnd_r        <= 4'd0;
            fsm_r        <= DONE;
          end else begin
            rnd_r <= rnd_r + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
`ifdef AES_ENC_BACK2BACK_EN
            if (in_valid) begin
              data_r <= plaintext ^ key;
              key_r  <= key;
              rnd_r  <= 4'd1;
              busy_r <= 1'b1;
              fsm_r  <= RUN;
            end else begin
              in_ready_r <= 1'b1;
              fsm_r      <= IDLE;
            end
`else
            in_ready_r <= 1'b1;
            fsm_r      <= IDLE;
`endif
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          fsm_r       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          rnd_r       <= 4'd0;
        end
      endcase
    end
  end

`ifdef AES_ENC_BACK2BACK_EN
  assign in_ready = in_ready_r | ((fsm_r == DONE) & out_ready);
`else
  assign in_ready = in_ready_r;
`endif
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign ciphertext = ciphertext_r;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed self-checking bench for aes_encrypt_iter using FIPS-197 vectors.
module tb_aes_encrypt_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  int n_checks;
  int n_fails;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_ENC_BACK2BACK_EN
  localparam int EXP_GAP = 11;
`else
  localparam int EXP_GAP = 12;
`endif

  aes_encrypt_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ticks until out_valid or a 50-cycle bound; reports cycles and busy samples.
  task automatic wait_out(output int n, output int bcnt);
    n = 0;
    bcnt = busy ? 1 : 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
  endtask

  initial begin
    int n, bcnt, gap;
    logic got1;
    logic [127:0] held;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = 128'h0; key = 128'h0;
    tick(); tick();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ct", ciphertext, 128'h0);
    rst = 1'b0;
    tick();

    // App. C.1 with latency and busy-length checks.
    plaintext = C1_PT; key = C1_KEY; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("c1_busy_run", 128'(busy), 128'd1);
    chk("c1_in_ready_run", 128'(in_ready), 128'd0);
    wait_out(n, bcnt);
    chk("c1_latency", 128'(n), 128'd10);
    chk("c1_busy_cycles", 128'(bcnt), 128'd10);
    chk("c1_ct", ciphertext, C1_CT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("c1_ov_drop", 128'(out_valid), 128'd0);
    tick();
    chk("c1_idle_ready", 128'(in_ready), 128'd1);

    // App. B with inputs scrambled during RUN, then 20 cycles of backpressure.
    plaintext = B_PT; key = B_KEY; in_valid = 1'b1;
    tick();
    plaintext = 128'hdeadbeef_00000000_cafef00d_12345678;
    key = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;
    in_valid = 1'b0;
    wait_out(n, bcnt);
    chk("b_latency", 128'(n), 128'd10);
    chk("b_ct", ciphertext, B_CT);
    held = ciphertext;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      plaintext = {4{$urandom()}};
      tick();
      chk("bp_ct_stable", ciphertext, held);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ov", 128'(out_valid), 128'd0);
    chk("bp_release_busy", 128'(busy), 128'd0);
    tick();
    chk("bp_idle_ready", 128'(in_ready), 128'd1);
    chk("bp_ct_kept", ciphertext, B_CT);

    // Async reset in the middle of round 5.
    plaintext = C1_PT; key = C1_KEY; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 128'(out_valid), 128'd0);
    chk("mid_rst_ct", ciphertext, 128'h0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 128'(in_ready), 128'd1);
    chk("post_rst_ov", 128'(out_valid), 128'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n, bcnt);
    chk("post_rst_latency", 128'(n), 128'd10);
    chk("post_rst_ct", ciphertext, C1_CT);
    out_ready = 1'b1;
    tick();

    // Back-to-back: out_ready held high, in_valid held high.
    plaintext = C1_PT; key = C1_KEY; in_valid = 1'b1;
    tick();
    plaintext = B_PT; key = B_KEY;
    gap = 0;
    got1 = 1'b0;
    do begin
      tick();
      gap++;
      if (out_valid && !got1) begin
        chk("b2b_ct1", ciphertext, C1_CT);
        got1 = 1'b1;
      end
    end while (!in_ready && gap < 50);
    tick();
    in_valid = 1'b0;
    chk("b2b_gap", 128'(gap + 1), 128'(EXP_GAP));
    chk("b2b_seen1", 128'(got1), 128'd1);
    chk("b2b_busy2", 128'(busy), 128'd1);
    wait_out(n, bcnt);
    chk("b2b_latency2", 128'(n), 128'd10);
    chk("b2b_ct2", ciphertext, B_CT);
    tick();
    chk("b2b_done_ov", 128'(out_valid), 128'd0);
    out_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative AES-128 encryption engine: one 128-bit plaintext block and one 128-bit cipher key are accepted over a valid/ready handshake. Ten rounds are computed, one round per clock. Round keys are generated on the fly. The ciphertext is presented over a second valid/ready handshake. It is the encrypt-side counterpart of the team's AES-128 decrypt path and uses the same FIPS-197 byte ordering, so output blocks feed the decryptor directly.

## Interface
Parameters:
- None. AES-128 only: Nk=4, Nr=10.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  engine can accept a block
- plaintext  in  128  block; bits [127:120] = byte 0 (FIPS-197 column-major)
- key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer takes ciphertext
- ciphertext  out  128  encrypted block
- busy  out  1  high while rounds are in progress (RUN state)

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, ciphertext=0, round counter=0, internal state/key registers=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg <= plaintext ^ key (initial AddRoundKey), key_reg <= key, rnd <= 1, go to RUN.
- RUN:
  - Each cycle: state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk_next).
  - rk_next = KeyExpand(key_reg, Rcon[rnd]); key_reg <= rk_next; rnd <= rnd+1.
  - Round 10 omits MixColumns; its result is loaded into ciphertext, then go to DONE.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; ciphertext is held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE, out_valid <= 0.
- Round counter is 4 bits, range 1..10, and never wraps; values 11..15 are unreachable. In RUN, rnd==10 is the terminal round.
- Rcon: 01,02,04,08,10,20,40,80,1b,36.
- GF(2^8) arithmetic uses the polynomial x^8+x^4+x^3+x+1. xtime reduces with 0x1b.
- plaintext and key are sampled only on the accept edge; later input changes have no effect.
- Async rst at any time (including mid-RUN or in DONE with out_ready low) returns all registers to reset values immediately. The block in flight is discarded and no out_valid pulse is produced.

## Timing
- Accept edge T: IDLE→RUN. Rounds 1..10 complete on edges T+1..T+10.
- out_valid rises after edge T+10. Latency is 10 cycles accept→out_valid.
- Earliest next accept (macro off): edge after the output handshake edge, giving a throughput of 1 block / 12 cycles.
- out_valid&&!out_ready: hold indefinitely; ciphertext is unchanged.
- busy=1 exactly in RUN, i.e. 10 cycles per block.

## Configuration
- AES_ENC_BACK2BACK_EN defined:
  - in DONE, in_ready = out_ready.
  - A simultaneous output handshake and input accept on the same edge goes DONE→RUN directly. It loads the new block and deasserts out_valid.
  - Throughput is 1 block / 11 cycles.
- Not defined: in_ready=1 only in IDLE; DONE always returns to IDLE first.

## Structure
- Package aes_pkg holds:
  - sbox lookup function
  - xtime function
  - Rcon constant array
  - state enum {IDLE, RUN, DONE}
  - 128-bit block typedef
  - byte-index helper for column-major order
- Sub-module aes_round_enc is combinational: inputs state, round key and a final flag; output the next state. It performs SubBytes, ShiftRows, MixColumns (bypassed when final=1) and AddRoundKey.
- The key expansion step is inline in the top module (RotWord, SubWord, Rcon, word XOR chain).

## Test plan
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid, toggling in_valid/plaintext meanwhile → ciphertext stable, in_ready=0, no new accept; release → one handshake, then IDLE.
- Reset mid-RUN: assert rst at round 5 → out_valid, ciphertext and busy go to 0 immediately; after release, in_ready=1 and the App. C.1 vector passes.
- Back-to-back (run with AES_ENC_BACK2BACK_EN and without): two blocks with out_ready=1 held → accept edges 11 cycles apart with the macro, 12 without; both ciphertexts correct.
- Input change after accept: alter plaintext/key during RUN → result matches the values sampled at accept.
